// File: rtl/src_arbiter.sv
// Round-robin arbiter that shares one NoC router injection port among NUM_SRC sources.
// Each grant allows a burst of up to MAX_BURST flits and then costs one arbitration bubble.
module src_arbiter #(
    parameter int WIDTH        = 32,
    parameter int N            = 16,
    parameter int N_ADDR_WIDTH = $clog2(N),
    parameter int NUM_SRC      = 4,
    parameter int MAX_BURST    = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_SRC*WIDTH-1:0]        src_data_in,
    input  logic [NUM_SRC*N_ADDR_WIDTH-1:0] src_dest_in,
    input  logic [NUM_SRC-1:0]              src_valid_in,
    output logic [NUM_SRC-1:0]              src_ready_out,
    output logic [WIDTH-1:0]                data_out,
    output logic [N_ADDR_WIDTH-1:0]         dest_out,
    output logic                            valid_out,
    input  logic                            ready_in,
    output logic [NUM_SRC-1:0]              grant_out
);

    localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [NUM_SRC-1:0] ONE_HOT0   = {{(NUM_SRC-1){1'b0}}, 1'b1};
    localparam logic [PTR_W-1:0]   LAST_SRC   = PTR_W'(NUM_SRC - 1);
    localparam logic [CNT_W-1:0]   BURST_LAST = CNT_W'(MAX_BURST);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t                  state_r, state_nxt_s;
    logic [NUM_SRC-1:0]      grant_r, grant_nxt_s;
    logic [PTR_W-1:0]        rr_ptr_r, rr_ptr_nxt_s;
    logic [CNT_W-1:0]        burst_cnt_r, burst_cnt_nxt_s, burst_inc_s;
    logic [WIDTH-1:0]        data_r;
    logic [N_ADDR_WIDTH-1:0] dest_r;
    logic                    valid_r;

    logic                    slot_free_s;
    logic                    sel_valid_s;
    logic [WIDTH-1:0]        sel_data_s;
    logic [N_ADDR_WIDTH-1:0] sel_dest_s;
    logic                    xfer_s;
    logic                    win_found_s;
    logic [PTR_W-1:0]        win_idx_s;

    // While granted, rr_ptr_r holds the owner index, so it doubles as the source mux select.
    assign sel_valid_s = src_valid_in[rr_ptr_r];
    assign sel_data_s  = src_data_in[int'(rr_ptr_r)*WIDTH +: WIDTH];
    assign sel_dest_s  = src_dest_in[int'(rr_ptr_r)*N_ADDR_WIDTH +: N_ADDR_WIDTH];

    assign slot_free_s   = ~valid_r | ready_in;
    assign xfer_s        = (state_r == GRANT) & slot_free_s & sel_valid_s;
    assign src_ready_out = ((state_r == GRANT) && slot_free_s) ? grant_r : {NUM_SRC{1'b0}};
    assign burst_inc_s   = burst_cnt_r + CNT_W'(1);

    assign data_out  = data_r;
    assign dest_out  = dest_r;
    assign valid_out = valid_r;
    assign grant_out = grant_r;

    // Round-robin search: scan downwards so the closest requester after rr_ptr_r wins.
    always_comb begin
        win_found_s = 1'b0;
        win_idx_s   = {PTR_W{1'b0}};
        for (int k = NUM_SRC; k >= 1; k--) begin
            win_found_s = src_valid_in[(int'(rr_ptr_r) + k) % NUM_SRC] ? 1'b1 : win_found_s;
            win_idx_s   = src_valid_in[(int'(rr_ptr_r) + k) % NUM_SRC] ?
                          PTR_W'((int'(rr_ptr_r) + k) % NUM_SRC) : win_idx_s;
        end
    end

    // Next-state logic for the grant FSM, round-robin pointer and burst counter.
    always_comb begin
        state_nxt_s     = state_r;
        grant_nxt_s     = grant_r;
        rr_ptr_nxt_s    = rr_ptr_r;
        burst_cnt_nxt_s = burst_cnt_r;
        case (state_r)
            IDLE: begin
                if (win_found_s) begin
                    state_nxt_s     = GRANT;
                    grant_nxt_s     = ONE_HOT0 << win_idx_s;
                    rr_ptr_nxt_s    = win_idx_s;
                    burst_cnt_nxt_s = {CNT_W{1'b0}};
                end else begin
                    state_nxt_s = IDLE;
                    grant_nxt_s = {NUM_SRC{1'b0}};
                end
            end
            GRANT: begin
                if (slot_free_s) begin
                    if (sel_valid_s) begin
                        burst_cnt_nxt_s = burst_inc_s;
                        if (burst_inc_s == BURST_LAST) begin
                            state_nxt_s = IDLE;
                            grant_nxt_s = {NUM_SRC{1'b0}};
                        end else begin
                            state_nxt_s = GRANT;
                        end
                    end else begin
                        state_nxt_s = IDLE;
                        grant_nxt_s = {NUM_SRC{1'b0}};
                    end
                end else begin
                    // Router stall freezes the grant; release is only evaluated once the slot frees.
                    state_nxt_s = GRANT;
                end
            end
            default: begin
                state_nxt_s     = IDLE;
                grant_nxt_s     = {NUM_SRC{1'b0}};
                burst_cnt_nxt_s = {CNT_W{1'b0}};
            end
        endcase
    end

    // Arbitration state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            grant_r     <= {NUM_SRC{1'b0}};
            rr_ptr_r    <= LAST_SRC;
            burst_cnt_r <= {CNT_W{1'b0}};
        end else begin
            state_r     <= state_nxt_s;
            grant_r     <= grant_nxt_s;
            rr_ptr_r    <= rr_ptr_nxt_s;
            burst_cnt_r <= burst_cnt_nxt_s;
        end
    end

    // Router-side output register: loads on a source transfer, holds while the router stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_r <= 1'b0;
            data_r  <= {WIDTH{1'b0}};
            dest_r  <= {N_ADDR_WIDTH{1'b0}};
        end else if (xfer_s) begin
            valid_r <= 1'b1;
            data_r  <= sel_data_s;
            dest_r  <= sel_dest_s;
        end else if (ready_in) begin
            valid_r <= 1'b0;
        end else begin
            valid_r <= valid_r;
        end
    end

endmodule

// File: tb/tb_src_arbiter.sv
// Directed bench for src_arbiter: a MAX_BURST=4 instance for most scenarios and a
// MAX_BURST=1 instance sharing the same inputs for the single-requester case.
module tb_src_arbiter;

    logic         clk;
    logic         rst;
    logic [127:0] src_data;
    logic [15:0]  src_dest;
    logic [3:0]   src_valid;
    logic         ready;
    logic [3:0]   src_ready0, src_ready1;
    logic [31:0]  data0, data1;
    logic [3:0]   dest0, dest1;
    logic         v0, v1;
    logic [3:0]   grant0, grant1;

    int           check_cnt;
    int           err_cnt;
    int           src_xfer_cnt;
    bit           auto_data;
    logic [7:0]   seq [4];
    logic [31:0]  rlog_data [$];
    logic [3:0]   rlog_dest [$];
    logic [3:0]   g_trace [32];

    src_arbiter #(.WIDTH(32), .N(16), .NUM_SRC(4), .MAX_BURST(4)) u_dut0 (
        .clk(clk), .rst(rst), .src_data_in(src_data), .src_dest_in(src_dest),
        .src_valid_in(src_valid), .src_ready_out(src_ready0), .data_out(data0),
        .dest_out(dest0), .valid_out(v0), .ready_in(ready), .grant_out(grant0)
    );

    src_arbiter #(.WIDTH(32), .N(16), .NUM_SRC(4), .MAX_BURST(1)) u_dut1 (
        .clk(clk), .rst(rst), .src_data_in(src_data), .src_dest_in(src_dest),
        .src_valid_in(src_valid), .src_ready_out(src_ready1), .data_out(data1),
        .dest_out(dest1), .valid_out(v1), .ready_in(ready), .grant_out(grant1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive source flits from the per-source sequence counters, then let outputs settle.
    task automatic settle();
        if (auto_data) begin
            for (int i = 0; i < 4; i++) begin
                src_data[i*32 +: 32] = {16'h0000, 8'(i), seq[i]};
                src_dest[i*4 +: 4]   = 4'(i + 1);
            end
        end
        #1;
    endtask

    // Record both handshakes for the coming edge, clock once, return at the next negedge.
    task automatic tick();
        logic [3:0] sx;
        sx = src_valid & src_ready0;
        if (v0 && ready) begin
            rlog_data.push_back(data0);
            rlog_dest.push_back(dest0);
        end
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            if (sx[i]) begin
                seq[i] = seq[i] + 8'd1;
                src_xfer_cnt++;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        src_valid = 4'b0000;
        ready = 1'b1;
        for (int i = 0; i < 4; i++) seq[i] = 8'd0;
        repeat (3) begin
            settle();
            tick();
        end
        rst = 1'b0;
        rlog_data.delete();
        rlog_dest.delete();
        src_xfer_cnt = 0;
    endtask

    task automatic check_log(input string tag, input int idx, input int src, input int s);
        if (idx < rlog_data.size()) begin
            check_eq(tag, rlog_data[idx], {16'h0000, 8'(src), 8'(s)});
            check_eq(tag, 32'(rlog_dest[idx]), 32'(src + 1));
        end else begin
            check_eq({tag, "_missing"}, 32'(rlog_data.size()), 32'(idx + 1));
        end
    endtask

    initial begin
        int order [5];
        int xfers20;
        logic seen2;
        check_cnt = 0;
        err_cnt = 0;
        src_xfer_cnt = 0;
        auto_data = 1'b0;
        src_data = 128'h0;
        src_dest = 16'h0;
        src_valid = 4'b0000;
        ready = 1'b1;
        rst = 1'b1;
        for (int i = 0; i < 4; i++) seq[i] = 8'd0;
        @(negedge clk);

        // Reset and basic single transfer.
        settle();
        check_eq("rst_valid", 32'(v0), 32'd0);
        check_eq("rst_grant", 32'(grant0), 32'd0);
        check_eq("rst_ready", 32'(src_ready0), 32'd0);
        check_eq("rst_data", data0, 32'd0);
        check_eq("rst_dest", 32'(dest0), 32'd0);
        repeat (3) tick();
        rst = 1'b0;
        src_valid = 4'b0001;
        src_data[31:0] = 32'h0000_00A5;
        src_dest[3:0] = 4'd7;
        settle();
        check_eq("basic_c0_grant", 32'(grant0), 32'd0);
        tick();
        settle();
        check_eq("basic_c1_grant", 32'(grant0), 32'b0001);
        check_eq("basic_c1_ready", 32'(src_ready0), 32'b0001);
        tick();
        settle();
        check_eq("basic_c2_valid", 32'(v0), 32'd1);
        check_eq("basic_c2_data", data0, 32'h0000_00A5);
        check_eq("basic_c2_dest", 32'(dest0), 32'd7);
        src_valid = 4'b0000;
        tick();
        settle();
        check_eq("basic_c3_valid", 32'(v0), 32'd0);
        check_eq("basic_c3_grant", 32'(grant0), 32'd0);

        // Full contention: grant order 0,1,2,3,0 with one bubble per grant.
        do_reset();
        auto_data = 1'b1;
        src_valid = 4'b1111;
        xfers20 = 0;
        for (int c = 0; c < 25; c++) begin
            settle();
            g_trace[c] = grant0;
            tick();
            if (c == 19) xfers20 = src_xfer_cnt;
        end
        src_valid = 4'b0000;
        repeat (3) begin
            settle();
            tick();
        end
        check_eq("cont_xfers_20cyc", 32'(xfers20), 32'd16);
        check_eq("cont_g_c1", 32'(g_trace[1]), 32'b0001);
        check_eq("cont_g_c5", 32'(g_trace[5]), 32'b0000);
        check_eq("cont_g_c6", 32'(g_trace[6]), 32'b0010);
        check_eq("cont_g_c11", 32'(g_trace[11]), 32'b0100);
        check_eq("cont_g_c16", 32'(g_trace[16]), 32'b1000);
        check_eq("cont_g_c21", 32'(g_trace[21]), 32'b0001);
        check_eq("cont_log_size", 32'(rlog_data.size()), 32'd20);
        order = '{0, 1, 2, 3, 0};
        for (int j = 0; j < 20; j++) check_log("cont_flit", j, order[j/4], (j < 16) ? j % 4 : 4 + j % 4);

        // Backpressure during a src1 burst.
        do_reset();
        src_valid = 4'b0010;
        repeat (3) begin
            settle();
            tick();
        end
        ready = 1'b0;
        for (int c = 3; c < 8; c++) begin
            settle();
            check_eq("bp_valid", 32'(v0), 32'd1);
            check_eq("bp_data", data0, 32'h0000_0101);
            check_eq("bp_dest", 32'(dest0), 32'd2);
            check_eq("bp_ready", 32'(src_ready0), 32'd0);
            check_eq("bp_grant", 32'(grant0), 32'b0010);
            tick();
        end
        ready = 1'b1;
        settle();
        tick();
        settle();
        check_eq("bp_c9_grant", 32'(grant0), 32'b0010);
        tick();
        src_valid = 4'b0000;
        settle();
        check_eq("bp_c10_grant", 32'(grant0), 32'd0);
        tick();
        settle();
        tick();
        check_eq("bp_log_size", 32'(rlog_data.size()), 32'd4);
        for (int j = 0; j < 4; j++) check_log("bp_flit", j, 1, j);

        // Early release by src2 after two transfers, src3 waiting.
        do_reset();
        src_valid = 4'b1100;
        settle();
        tick();
        settle();
        check_eq("er_c1_grant", 32'(grant0), 32'b0100);
        tick();
        settle();
        tick();
        src_valid = 4'b1000;
        settle();
        tick();
        settle();
        check_eq("er_c4_grant", 32'(grant0), 32'd0);
        check_eq("er_c4_ready", 32'(src_ready0), 32'd0);
        seen2 = src_ready0[2];
        tick();
        settle();
        check_eq("er_c5_grant", 32'(grant0), 32'b1000);
        check_eq("er_c5_ready", 32'(src_ready0), 32'b1000);
        for (int c = 5; c < 11; c++) begin
            if (c == 9) src_valid = 4'b0000;
            settle();
            seen2 = seen2 | src_ready0[2];
            tick();
        end
        check_eq("er_src2_no_ready", 32'(seen2), 32'd0);
        check_eq("er_log_size", 32'(rlog_data.size()), 32'd6);
        check_log("er_flit", 0, 2, 0);
        check_log("er_flit", 1, 2, 1);
        for (int j = 0; j < 4; j++) check_log("er_flit", j + 2, 3, j);

        // Asynchronous reset in the middle of a src1 burst.
        do_reset();
        src_valid = 4'b0010;
        repeat (2) begin
            settle();
            tick();
        end
        settle();
        check_eq("ar_pre_valid", 32'(v0), 32'd1);
        check_eq("ar_pre_grant", 32'(grant0), 32'b0010);
        #2;
        rst = 1'b1;
        #1;
        check_eq("ar_valid", 32'(v0), 32'd0);
        check_eq("ar_grant", 32'(grant0), 32'd0);
        check_eq("ar_ready", 32'(src_ready0), 32'd0);
        src_valid = 4'b1111;
        @(negedge clk);
        rst = 1'b0;
        settle();
        check_eq("ar_c0_grant", 32'(grant0), 32'd0);
        tick();
        settle();
        check_eq("ar_c1_grant", 32'(grant0), 32'b0001);
        src_valid = 4'b0000;
        repeat (6) begin
            settle();
            tick();
        end

        // Single requester src3 on the MAX_BURST=1 instance.
        do_reset();
        auto_data = 1'b0;
        src_data[127:96] = 32'hC3C3_0003;
        src_dest[15:12] = 4'd9;
        src_valid = 4'b1000;
        xfers20 = 0;
        for (int c = 0; c < 9; c++) begin
            settle();
            if (c >= 1) check_eq("sr_grant", 32'(grant1), (c % 2 == 1) ? 32'b1000 : 32'b0000);
            if (c >= 2) check_eq("sr_valid", 32'(v1), (c % 2 == 0) ? 32'd1 : 32'd0);
            if (c >= 2 && c % 2 == 0) begin
                check_eq("sr_data", data1, 32'hC3C3_0003);
                check_eq("sr_dest", 32'(dest1), 32'd9);
            end
            if (src_valid[3] && src_ready1[3]) xfers20++;
            tick();
        end
        check_eq("sr_xfers", 32'(xfers20), 32'd4);
        src_valid = 4'b0000;

        $display("Simulation finished: %0d checks, %0d errors", check_cnt, err_cnt);
        $finish;
    end

endmodule
